pool_window_2x2: RTL and testbench
==================================

// Module: pool_window_2x2
// PURPOSE
//   Upstream feeder for the 2x2 max-pool comparator stage. Accepts one feature-map
//   pixel per valid cycle in raster order (row-major, one channel plane), buffers
//   one line, and emits each non-overlapping 2x2 window (stride 2) as four parallel
//   words plus a one-cycle valid strobe, ready to drive the comparator's in1..in4.
// PARAMETERS
//   DATA_WIDTH  32   pixel word width (opaque; no arithmetic performed)
//   IMG_WIDTH   224  pixels per row; must be even, >= 2
//   IMG_HEIGHT  224  rows per frame; must be even, >= 2
//   (localparams: COL_W = clog2(IMG_WIDTH), ROW_W = clog2(IMG_HEIGHT))
// PORTS
//   clk         in   1           clock, rising edge
//   resetn      in   1           asynchronous, active-low reset
//   valid_in    in   1           data_in carries the next raster pixel this cycle
//   data_in     in   DATA_WIDTH  pixel value
//   out1        out  DATA_WIDTH  window top-left     (row 2r,   col 2c)
//   out2        out  DATA_WIDTH  window top-right    (row 2r,   col 2c+1)
//   out3        out  DATA_WIDTH  window bottom-left  (row 2r+1, col 2c)
//   out4        out  DATA_WIDTH  window bottom-right (row 2r+1, col 2c+1)
//   valid_out   out  1           one-cycle strobe: out1..out4 hold a new window
//   frame_done  out  1           one-cycle strobe coincident with last window's valid_out
// BEHAVIOUR
//   - Reset (async assert, sync release): col=0, row=0, out1..out4=0, valid_out=0,
//     frame_done=0, bottom-left hold reg=0. Line buffer contents need not be cleared.
//   - Counters advance only on valid_in=1; idle cycles (gaps) change no state except
//     valid_out/frame_done returning to 0. col wraps W-1 -> 0 and increments row;
//     row wraps H-1 -> 0 (back-to-back frames need no idle cycle).
//   - Even row (row[0]=0): linebuf[col] <= data_in. No output.
//   - Odd row, even col: hold_bl <= data_in. No output.
//   - Odd row, odd col: on that same edge register
//     out1<=linebuf[col-1], out2<=linebuf[col], out3<=hold_bl, out4<=data_in,
//     valid_out<=1. Latency: valid_out high exactly 1 cycle after the bottom-right
//     pixel's valid_in cycle. Throughput: one window per 2 pixels on odd rows.
//   - frame_done<=1 in the same cycle as valid_out when that window used
//     row=H-1, col=W-1.
//   - When no window is produced, valid_out=frame_done=0 and out1..out4 hold their
//     previous values (downstream samples only on valid_out).
//   - Line buffer: IMG_WIDTH x DATA_WIDTH register array (or inferred RAM with
//     same-cycle write/registered read equivalence); odd-row reads never address a
//     location written in the same cycle, so no bypass is required.
//   - Reset mid-frame: partial window discarded; first valid pixel after release is
//     pixel (0,0) of a new frame.
//   - No backpressure: downstream consumes every window (comparator stage always
//     accepts). Values passed through bit-exact, no sign handling.
// TESTING
//   W=4,H=4, pixels 0..15 on consecutive cycles -> 4 valid_out pulses with
//     (out1..4) = (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15); each 1 cycle after
//     pixels 5,7,13,15; frame_done only with the last.
//   Same frame with random 0-3 cycle valid_in gaps -> identical window sequence;
//     outputs stable and valid_out=0 during gaps.
//   Two frames back-to-back (pixels 0..15 then 100..115) -> second frame windows
//     (100,101,104,105)...(110,111,114,115); frame_done pulses twice.
//   Signed extremes: 0x80000000, 0x7FFFFFFF, 0xFFFFFFFF, 0 in one window ->
//     delivered bit-exact in positions out1..out4.
//   Assert resetn low after pixel 6 of frame, release, send 0..15 -> all outputs 0
//     during reset; then exactly the 4 windows of the new frame, no stale window.
//   Default params (224x224) full frame -> 12544 valid_out pulses, 1 frame_done.

Source files
------------

// File: rtl/pool_window_2x2_if.sv
`default_nettype none
// ============================================================================
// Module  : pool_window_2x2_if
// Brief   : Pixel stream in / 2x2 window out bundle for the max-pool feeder.
// Revision: 1.0
// ============================================================================
interface pool_window_2x2_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] out1;
   logic [DATA_WIDTH-1:0] out2;
   logic [DATA_WIDTH-1:0] out3;
   logic [DATA_WIDTH-1:0] out4;
   logic                  valid_out;
   logic                  frame_done;

   modport master (
      output valid_in, data_in,
      input  out1, out2, out3, out4, valid_out, frame_done
   );

   modport slave (
      input  valid_in, data_in,
      output out1, out2, out3, out4, valid_out, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/pool_window_2x2.sv
`default_nettype none
// ============================================================================
// Module  : pool_window_2x2
// Brief   : Buffers one raster line and emits stride-2 2x2 windows as 4 words.
// Revision: 1.0
// ============================================================================
module pool_window_2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 224,
   parameter int IMG_HEIGHT = 224
) (
   input  wire logic          clk,
   input  wire logic          resetn,
   pool_window_2x2_if.slave   bus
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic [DATA_WIDTH-1:0] r_hold_bl;
   logic [DATA_WIDTH-1:0] r_out1, r_out2, r_out3, r_out4;
   logic                  r_valid_out;
   logic                  r_frame_done;
   logic [DATA_WIDTH-1:0] r_linebuf [IMG_WIDTH];

   logic                  w_col_last;
   logic                  w_row_last;
   logic [COL_W-1:0]      w_col_even;

   assign w_col_last = (r_col == c_col_last);
   assign w_row_last = (r_row == c_row_last);
   assign w_col_even = r_col & ~COL_W'(1);

   // Only even rows write; odd rows only read, so no bypass path is needed.
   always_ff @(posedge clk) begin
      if (bus.valid_in && !r_row[0]) begin
         r_linebuf[r_col] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hold_bl    <= '0;
         r_out1       <= '0;
         r_out2       <= '0;
         r_out3       <= '0;
         r_out4       <= '0;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.valid_in) begin
            r_col <= w_col_last ? '0 : r_col + COL_W'(1);
            if (w_col_last) begin
               r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end
            if (r_row[0]) begin
               if (!r_col[0]) begin
                  r_hold_bl <= bus.data_in;
               end else begin
                  r_out1       <= r_linebuf[w_col_even];
                  r_out2       <= r_linebuf[r_col];
                  r_out3       <= r_hold_bl;
                  r_out4       <= bus.data_in;
                  r_valid_out  <= 1'b1;
                  r_frame_done <= w_row_last && w_col_last;
               end
            end
         end
      end
   end

   assign bus.out1       = r_out1;
   assign bus.out2       = r_out2;
   assign bus.out3       = r_out3;
   assign bus.out4       = r_out4;
   assign bus.valid_out  = r_valid_out;
   assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_pool_window_2x2.sv
`default_nettype none
// ============================================================================
// Module  : tb_pool_window_2x2
// Brief   : Directed checks of the 2x2 window feeder on a 4x4 and a 224x224 frame.
// Revision: 1.0
// ============================================================================
module tb_pool_window_2x2;
   localparam int DW = 32;
   localparam int W  = 4;
   localparam int H  = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   pool_window_2x2_if #(.DATA_WIDTH(DW)) bus_s ();
   pool_window_2x2_if #(.DATA_WIDTH(DW)) bus_b ();

   pool_window_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_s)
   );

   pool_window_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(224), .IMG_HEIGHT(224)) u_big (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_b)
   );

   int total = 0;
   int bad   = 0;
   int big_win = 0;
   int big_fd  = 0;
   logic [DW-1:0] pix [16];
   logic [DW-1:0] e1, e2, e3, e4;

   always @(negedge clk) begin
      if (bus_b.valid_out)  big_win++;
      if (bus_b.frame_done) big_fd++;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic vo, input logic fd);
      chk({tag, ".valid_out"},  DW'(bus_s.valid_out),  DW'(vo));
      chk({tag, ".frame_done"}, DW'(bus_s.frame_done), DW'(fd));
      chk({tag, ".out1"}, bus_s.out1, e1);
      chk({tag, ".out2"}, bus_s.out2, e2);
      chk({tag, ".out3"}, bus_s.out3, e3);
      chk({tag, ".out4"}, bus_s.out4, e4);
   endtask

   // Sends pix[0..n-1]; the window completed by pixel i is expected one cycle later.
   task automatic send_frame(input string tag, input int n, input int max_gap);
      int r, c, gaps;
      for (int i = 0; i < n; i++) begin
         bus_s.valid_in = 1'b1;
         bus_s.data_in  = pix[i];
         @(negedge clk);
         r = i / W;
         c = i % W;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            e1 = pix[i-W-1];
            e2 = pix[i-W];
            e3 = pix[i-1];
            e4 = pix[i];
            check_outs(tag, 1'b1, (i == W*H-1));
         end else begin
            check_outs(tag, 1'b0, 1'b0);
         end
         bus_s.valid_in = 1'b0;
         gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            check_outs({tag, ".gap"}, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      bus_s.valid_in = 1'b0;
      bus_s.data_in  = '0;
      bus_b.valid_in = 1'b0;
      bus_b.data_in  = '0;
      e1 = '0; e2 = '0; e3 = '0; e4 = '0;

      repeat (3) @(negedge clk);
      check_outs("reset", 1'b0, 1'b0);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) pix[i] = DW'(i);
      send_frame("seq", 16, 0);

      send_frame("gaps", 16, 3);

      send_frame("b2b_a", 16, 0);
      for (int i = 0; i < 16; i++) pix[i] = DW'(100 + i);
      send_frame("b2b_b", 16, 0);

      for (int i = 0; i < 16; i++) pix[i] = DW'(200 + i);
      pix[0] = 32'h8000_0000;
      pix[1] = 32'h7FFF_FFFF;
      pix[4] = 32'hFFFF_FFFF;
      pix[5] = 32'h0000_0000;
      send_frame("extreme", 16, 0);

      for (int i = 0; i < 16; i++) pix[i] = DW'(i);
      send_frame("partial", 7, 0);
      #2 resetn = 1'b0;
      #1;
      e1 = '0; e2 = '0; e3 = '0; e4 = '0;
      check_outs("rst_async", 1'b0, 1'b0);
      @(negedge clk);
      check_outs("rst_hold", 1'b0, 1'b0);
      resetn = 1'b1;
      send_frame("after_rst", 16, 0);
      repeat (2) @(negedge clk);
      check_outs("idle_end", 1'b0, 1'b0);

      for (int n = 0; n < 224*224; n++) begin
         bus_b.valid_in = 1'b1;
         bus_b.data_in  = DW'(n);
         @(negedge clk);
      end
      bus_b.valid_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("big.windows",    DW'(big_win), DW'(12544));
      chk("big.frame_done", DW'(big_fd),  DW'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
